// File: rtl/pr_update_packer_pkg.sv
// Shared types and constants for the PageRank update packer.
// Update word is {value, dest}; a line is LANES updates plus a last flag.
package pr_update_packer_pkg;

    localparam int UPD_W  = 64;
    localparam int LANES  = 8;
    localparam int LINE_W = UPD_W * LANES;

    localparam logic [UPD_W-1:0] PAD_WORD = 64'h0000_0000_FFFF_FFFF;

    localparam int VALUE_MSB = 63;
    localparam int VALUE_LSB = 32;
    localparam int DEST_MSB  = 31;
    localparam int DEST_LSB  = 0;

    typedef struct packed {
        logic [LINE_W-1:0] data;
        logic              last;
    } line_t;

endpackage

// File: rtl/pr_line_fifo.sv
// First-word-fall-through line FIFO; head entry is visible while not empty.
// A push into a full FIFO is taken only if a pop happens on the same edge.
module pr_line_fifo #(
    parameter int W     = 513,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pr_update_packer.sv
// Packs scatter-stage updates into 512-bit lines, buffers them, and
// closes partitions on flush with a padded last line and a done pulse.
module pr_update_packer
    import pr_update_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [UPD_W-1:0]  upd_word,
    input  logic              upd_valid,
    input  logic              flush,
    output logic [LINE_W-1:0] line_data,
    output logic              line_last,
    output logic              line_valid,
    input  logic              line_ready,
    output logic              flush_done,
    output logic              busy,
    output logic              overflow,
    output logic [CNT_W-1:0]  upd_count
);

    logic [LANES-1:0][UPD_W-1:0] lane_q;
    logic [LANES-1:0][UPD_W-1:0] lane_w;
    logic [2:0]                  lane_cnt;
    logic [3:0]                  cnt_after;
    logic                        line_full;
    logic                        push;
    line_t                       push_line;
    line_t                       head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        pop;
    logic                        drop;
    logic [FIFO_AW:0]            pending;
    logic                        pend_inc;
    logic                        pend_dec;

    // Resolve the concurrent update first, then decide what a flush closes.
    always_comb begin
        lane_w = lane_q;
        if (upd_valid) begin
            lane_w[lane_cnt] = upd_word;
        end
        cnt_after = {1'b0, lane_cnt} + {3'b000, upd_valid};
        line_full = (cnt_after == 4'd8);
        push      = line_full || flush;
        push_line.last = flush;
        for (int k = 0; k < LANES; k++) begin
            push_line.data[k*UPD_W +: UPD_W] =
                (4'(k) < cnt_after) ? lane_w[k] : PAD_WORD;
        end
    end

    pr_line_fifo #(
        .W     ($bits(line_t)),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_line),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign line_valid = !fifo_empty;
    assign line_data  = head.data;
    assign line_last  = head.last;
    assign pop        = line_valid && line_ready;
    assign drop       = push && fifo_full && !pop;

    // A dropped last line still retires its flush so busy can clear.
    assign pend_inc = flush;
    assign pend_dec = (pop && head.last) || (drop && push_line.last);

    assign busy = (lane_cnt != '0) || !fifo_empty || (pending != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q     <= '0;
            lane_cnt   <= '0;
            pending    <= '0;
            flush_done <= 1'b0;
            overflow   <= 1'b0;
            upd_count  <= '0;
        end else begin
            lane_q     <= lane_w;
            flush_done <= pop && head.last;
            if (push) begin
                lane_cnt <= '0;
            end else if (upd_valid) begin
                lane_cnt <= lane_cnt + 3'd1;
            end
            if (upd_valid) begin
                upd_count <= upd_count + CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            unique case ({pend_inc, pend_dec})
                2'b10:   pending <= pending + (FIFO_AW+1)'(1);
                2'b01:   pending <= pending - (FIFO_AW+1)'(1);
                default: pending <= pending;
            endcase
        end
    end

endmodule

// File: tb/tb_pr_update_packer.sv
// Directed self-checking bench for pr_update_packer.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pr_update_packer;
    import pr_update_packer_pkg::*;

    logic              clk;
    logic              rst;
    logic [UPD_W-1:0]  upd_word;
    logic              upd_valid;
    logic              flush;
    logic [LINE_W-1:0] line_data;
    logic              line_last;
    logic              line_valid;
    logic              line_ready;
    logic              flush_done;
    logic              busy;
    logic              overflow;
    logic [31:0]       upd_count;

    int checks;
    int errors;
    logic [31:0] exp_cnt;

    pr_update_packer dut (
        .clk        (clk),
        .rst        (rst),
        .upd_word   (upd_word),
        .upd_valid  (upd_valid),
        .flush      (flush),
        .line_data  (line_data),
        .line_last  (line_last),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .flush_done (flush_done),
        .busy       (busy),
        .overflow   (overflow),
        .upd_count  (upd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] vb,
                                                  input logic [31:0] db,
                                                  input int n);
        logic [LINE_W-1:0] r;
        for (int k = 0; k < LANES; k++) begin
            if (k < n) r[k*UPD_W +: UPD_W] = {vb + 32'(k), db + 32'(k)};
            else       r[k*UPD_W +: UPD_W] = PAD_WORD;
        end
        return r;
    endfunction

    // One cycle of stimulus, returning at the next falling edge.
    task automatic cyc(input logic v, input logic [63:0] w, input logic f);
        upd_valid = v;
        upd_word  = w;
        flush     = f;
        if (v) exp_cnt = exp_cnt + 32'd1;
        @(negedge clk);
        upd_valid = 1'b0;
        flush     = 1'b0;
        upd_word  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        upd_valid = 1'b0;
        flush = 1'b0;
        upd_word = '0;
        line_ready = 1'b1;
        exp_cnt = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({line_valid, flush_done, busy, overflow} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got v%b d%b b%b o%b, want 0000",
                     line_valid, flush_done, busy, overflow);
        end
        checks++;
        if (upd_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d, want 0", upd_count);
        end
    endtask

    task automatic test_full_line();
        logic [LINE_W-1:0] e;
        e = mk_line(32'h100, 32'd0, 8);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (line_valid !== 1'b0) begin
                errors++;
                $display("FAIL full_early_valid: lane %0d got %b, want 0",
                         k, line_valid);
            end
            cyc(1'b1, {32'h100 + 32'(k), 32'(k)}, 1'b0);
        end
        checks++;
        if (line_valid !== 1'b1 || line_last !== 1'b0) begin
            errors++;
            $display("FAIL full_valid: got v%b l%b, want v1 l0",
                     line_valid, line_last);
        end
        checks++;
        if (line_data !== e) begin
            errors++;
            $display("FAIL full_data: got %h, want %h", line_data, e);
        end
        checks++;
        if (upd_count !== exp_cnt) begin
            errors++;
            $display("FAIL full_count: got %0d, want %0d", upd_count, exp_cnt);
        end
        @(negedge clk);
        checks++;
        if ({line_valid, busy, flush_done} !== 3'b000) begin
            errors++;
            $display("FAIL full_drain: got v%b b%b d%b, want 000",
                     line_valid, busy, flush_done);
        end
    endtask

    task automatic test_partial_flush();
        logic [LINE_W-1:0] e;
        e = mk_line(32'hA0, 32'd20, 3);
        for (int k = 0; k < 3; k++) cyc(1'b1, {32'hA0 + 32'(k), 32'd20 + 32'(k)}, 1'b0);
        checks++;
        if (busy !== 1'b1 || line_valid !== 1'b0) begin
            errors++;
            $display("FAIL part_hold: got b%b v%b, want b1 v0", busy, line_valid);
        end
        cyc(1'b0, '0, 1'b1);
        checks++;
        if (line_valid !== 1'b1 || line_last !== 1'b1 || line_data !== e) begin
            errors++;
            $display("FAIL part_line: got v%b l%b %h, want v1 l1 %h",
                     line_valid, line_last, line_data, e);
        end
        checks++;
        if (flush_done !== 1'b0) begin
            errors++;
            $display("FAIL part_done_early: got %b, want 0", flush_done);
        end
        @(negedge clk);
        checks++;
        if (flush_done !== 1'b1 || busy !== 1'b0 || line_valid !== 1'b0) begin
            errors++;
            $display("FAIL part_done: got d%b b%b v%b, want d1 b0 v0",
                     flush_done, busy, line_valid);
        end
        @(negedge clk);
        checks++;
        if (flush_done !== 1'b0) begin
            errors++;
            $display("FAIL part_done_pulse: got %b, want 0", flush_done);
        end
    endtask

    task automatic test_empty_flush();
        logic [LINE_W-1:0] e;
        e = mk_line(32'd0, 32'd0, 0);
        cyc(1'b0, '0, 1'b1);
        checks++;
        if (line_valid !== 1'b1 || line_last !== 1'b1 || line_data !== e) begin
            errors++;
            $display("FAIL empty_line: got v%b l%b %h, want v1 l1 %h",
                     line_valid, line_last, line_data, e);
        end
        @(negedge clk);
        checks++;
        if (flush_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: got d%b b%b, want d1 b0", flush_done, busy);
        end
    endtask

    task automatic test_flush_with_eighth();
        logic [LINE_W-1:0] e;
        e = mk_line(32'h300, 32'd40, 8);
        for (int k = 0; k < 7; k++) cyc(1'b1, {32'h300 + 32'(k), 32'd40 + 32'(k)}, 1'b0);
        cyc(1'b1, {32'h307, 32'd47}, 1'b1);
        checks++;
        if (line_valid !== 1'b1 || line_last !== 1'b1 || line_data !== e) begin
            errors++;
            $display("FAIL f8_line: got v%b l%b %h, want v1 l1 %h",
                     line_valid, line_last, line_data, e);
        end
        @(negedge clk);
        checks++;
        if (line_valid !== 1'b0 || flush_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL f8_single: got v%b d%b b%b, want v0 d1 b0",
                     line_valid, flush_done, busy);
        end
    endtask

    task automatic test_overflow();
        int bad;
        line_ready = 1'b0;
        for (int i = 0; i < 136; i++) cyc(1'b1, {32'h1000 + 32'(i), 32'(i)}, 1'b0);
        checks++;
        if (overflow !== 1'b1 || line_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got o%b v%b, want o1 v1", overflow, line_valid);
        end
        checks++;
        if (upd_count !== exp_cnt) begin
            errors++;
            $display("FAIL ovf_count: got %0d, want %0d", upd_count, exp_cnt);
        end
        line_ready = 1'b1;
        bad = 0;
        for (int l = 0; l < 16; l++) begin
            checks++;
            if (line_valid !== 1'b1 || line_last !== 1'b0 ||
                line_data !== mk_line(32'h1000 + 32'(8*l), 32'(8*l), 8)) begin
                errors++;
                bad++;
                if (bad < 4)
                    $display("FAIL ovf_line%0d: got v%b l%b %h", l,
                             line_valid, line_last, line_data);
            end
            @(negedge clk);
        end
        checks++;
        if (line_valid !== 1'b0 || overflow !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ovf_after: got v%b o%b b%b, want v0 o1 b0",
                     line_valid, overflow, busy);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        line_ready = 1'b0;
        for (int i = 0; i < 37; i++) cyc(1'b1, {32'h5000 + 32'(i), 32'(i)}, 1'b0);
        checks++;
        if (busy !== 1'b1 || line_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got b%b v%b, want b1 v1", busy, line_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({line_valid, busy, overflow} !== 3'b000 || upd_count !== 32'd0) begin
            errors++;
            $display("FAIL mid_async: got v%b b%b o%b c%0d, want 0 0 0 0",
                     line_valid, busy, overflow, upd_count);
        end
        @(negedge clk);
        rst = 1'b1;
        line_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (line_valid !== 1'b0 || busy !== 1'b0 || flush_done !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_quiet: got %0d active cycles, want 0", seen);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_line();
        test_partial_flush();
        test_empty_flush();
        test_flush_with_eighth();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pr_update_packer.md
Name: pr_update_packer

Overview:
- Sits directly downstream of the PageRank scatter stage. Consumes its 64-bit update stream ({value[63:32], dest[31:0]}, valid only, no backpressure).
- Packs 8 updates into one 512-bit line and buffers lines in a FIFO. Presents lines to the memory write channel with a valid/ready handshake.
- At end of a partition, flush closes the current line: padded, tagged last, with a completion pulse.

Parameters:
- UPD_W, 64, width of one update word.
- LANES, 8, updates per output line. LINE_W = UPD_W*LANES = 512.
- FIFO_DEPTH, 16, lines buffered; power of two.
- FIFO_AW, 4, log2(FIFO_DEPTH).
- CNT_W, 32, width of the accepted-update counter.
- PAD_WORD, 64'h0000_0000_FFFF_FFFF, filler for unused lanes (value 0, dest all-ones = "no vertex").

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- upd_word  in  64  update from scatter: [63:32] value, [31:0] dest.
- upd_valid  in  1  update present this cycle; always accepted.
- flush  in  1  single-cycle pulse; close the current partition.
- line_data  out  512  packed line; lane k occupies bits [64k+63:64k].
- line_last  out  1  line is the final line of a flushed partition.
- line_valid  out  1  line_data/line_last valid.
- line_ready  in  1  consumer accepts; transfer when line_valid && line_ready.
- flush_done  out  1  one-cycle pulse when a last line transfers.
- busy  out  1  partial lanes held, FIFO non-empty, or flush pending.
- overflow  out  1  sticky: a line was dropped because the FIFO was full.
- upd_count  out  CNT_W  number of accepted updates (upd_valid cycles).

Behaviour:
- Reset: all outputs 0. Lane counter 0, FIFO empty, pending-flush counter 0, overflow 0. Reset mid-operation discards partial lanes and FIFO contents; nothing is emitted after release.
- Packing:
  - Each upd_valid writes upd_word into lane lane_cnt, then lane_cnt increments.
  - When lane_cnt reaches 7 and an update arrives, the full line is pushed with last=0 on that edge and lane_cnt wraps to 0.
- upd_count: increments by 1 per upd_valid and wraps modulo 2^CNT_W. Dropped lines are still counted.
- Flush (any cycle), resolved after including a concurrent upd_valid:
  - resulting line full: push it with last=1.
  - else lane_cnt>0: fill remaining lanes with PAD_WORD and push with last=1.
  - else (empty): push an all-PAD_WORD line with last=1. Every flush yields exactly one last line.
  - lane_cnt returns to 0.
- upd_valid after a flush starts the next partition immediately; it does not wait for flush_done.
- Pending-flush counter (width FIFO_AW+1): +1 per flush, -1 per last-line transfer. Simultaneous +1/-1 leaves it unchanged.
- busy = (lane_cnt!=0) || FIFO non-empty || pending!=0. It drops in the cycle after the final transfer.
- FIFO:
  - First-word-fall-through; line_valid = !empty; line_data/line_last come from the head entry.
  - Latency: a line pushed on edge N with the FIFO empty shows line_valid=1 in cycle N+1.
  - Pop on valid&&ready.
  - Push when full is accepted if a pop occurs the same cycle. Otherwise the line is dropped and overflow is set, held until reset. If the dropped line had last=1, the pending counter still decrements so busy can clear.
- flush_done: registered pulse the cycle after a last=1 transfer.
- line_data and line_last are stable while line_valid && !line_ready.

Decomposition:
- Shared package:
  - UPD_W and LANES constants.
  - PAD_WORD.
  - update-word field offsets (VALUE_MSB=63, VALUE_LSB=32, DEST_MSB=31, DEST_LSB=0).
  - a line struct of 512-bit data plus last.
- One sub-module: pr_line_fifo. Parameterised width (LINE_W+1) and depth; FWFT; exposes full/empty and push/pop.
- Packing, flush logic and counters live in the top.

Test Plan:
- 8 updates (dest 0..7, value 0x100+k) back-to-back, line_ready=1 -> one line, lane k = {0x100+k, k}, last=0, line_valid 1 cycle after the 8th update; upd_count=8.
- 3 updates then flush -> one line with lanes 0-2 data, lanes 3-7 = 0x0000_0000_FFFF_FFFF, last=1. flush_done pulses one cycle after transfer; busy then 0.
- flush with zero lanes held -> single all-PAD line, last=1; flush_done pulses.
- 8th update and flush in the same cycle -> exactly one line (all data, last=1); no extra pad line.
- line_ready=0, stream 17 full lines -> 16 lines retained, overflow=1 sticky; after releasing ready, 16 lines out in order; upd_count=136.
- Reset pulse (rst=0) with 5 lanes held and 4 lines queued -> line_valid=0, busy=0, overflow=0, upd_count=0 immediately; no output after release.
